// File: rtl/trap_ctrl_if.sv
// Execute-stage event, CSR-port and fetch-redirect bundle for trap_ctrl.
// The slave side is the trap sequencer; the master side is the core around it.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic            is_ecall;
  logic            is_ebreak;
  logic            is_illegal;
  logic            is_mret;
  logic [XLEN-1:0] bad_instr;
  logic            irq_timer;
  logic            mstatus_mie;
  logic            csr_inst_we;
  logic [11:0]     csr_inst_addr;
  logic [XLEN-1:0] csr_inst_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] mtvec_in;
  logic [XLEN-1:0] mepc_in;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  instr_valid, pc, is_ecall, is_ebreak,
    input  is_illegal, is_mret, bad_instr,
    input  irq_timer, mstatus_mie,
    input  csr_inst_we, csr_inst_addr, csr_inst_wdata,
    input  csr_rdata, mtvec_in, mepc_in,
    output csr_we, csr_addr, csr_wdata,
    output stall, flush, redirect_valid, redirect_pc
  );

  modport master (
    output instr_valid, pc, is_ecall, is_ebreak,
    output is_illegal, is_mret, bad_instr,
    output irq_timer, mstatus_mie,
    output csr_inst_we, csr_inst_addr, csr_inst_wdata,
    output csr_rdata, mtvec_in, mepc_in,
    input  csr_we, csr_addr, csr_wdata,
    input  stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks one event by priority, walks the
// single CSR write port through mepc/mcause/mtval/mstatus, then redirects.
module trap_ctrl #(
  parameter int XLEN              = 32,
  parameter bit MTVEC_VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MCAUSE,
    T_MTVAL,
    T_MSTATUS,
    T_REDIR,
    M_MSTATUS,
    M_REDIR
  } state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  localparam logic [XLEN-1:0] CAUSE_IRQ =
    {1'b1, {(XLEN-4){1'b0}}, 3'd7};

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_rpc;
  logic [11:0]     r_addr;
  logic            r_irq;
  logic            r_we;
  logic            r_redir;

  logic            w_irq;
  logic            w_ill;
  logic            w_ebrk;
  logic            w_ecall;
  logic            w_mret;
  logic            w_trap;
  logic            w_evt;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_tval;
  logic [XLEN-1:0] w_ms_trap;
  logic [XLEN-1:0] w_ms_mret;
  logic [XLEN-1:0] w_tvec_base;
  logic [XLEN-1:0] w_tvec;

  // Priority masking makes the selects one-hot
  assign w_irq   = bus.instr_valid & bus.irq_timer
                 & bus.mstatus_mie;
  assign w_ill   = bus.instr_valid & bus.is_illegal
                 & ~w_irq;
  assign w_ebrk  = bus.instr_valid & bus.is_ebreak
                 & ~w_irq & ~bus.is_illegal;
  assign w_ecall = bus.instr_valid & bus.is_ecall
                 & ~w_irq & ~bus.is_illegal
                 & ~bus.is_ebreak;
  assign w_mret  = bus.instr_valid & bus.is_mret
                 & ~w_irq & ~bus.is_illegal
                 & ~bus.is_ebreak & ~bus.is_ecall;
  assign w_trap  = w_irq | w_ill | w_ebrk | w_ecall;
  assign w_evt   = (r_state == IDLE) & (w_trap | w_mret);

  always_comb begin
    w_cause = '0;
    w_tval  = '0;
    unique case (1'b1)
      w_irq:   w_cause = CAUSE_IRQ;
      w_ill: begin
        w_cause = XLEN'(2);
        w_tval  = bus.bad_instr;
      end
      w_ebrk:  w_cause = XLEN'(3);
      w_ecall: w_cause = XLEN'(11);
      default: ;
    endcase
  end

  always_comb begin
    w_ms_trap        = bus.csr_rdata;
    w_ms_trap[7]     = bus.csr_rdata[3];
    w_ms_trap[3]     = 1'b0;
    w_ms_trap[12:11] = 2'b11;
    w_ms_mret        = bus.csr_rdata;
    w_ms_mret[3]     = bus.csr_rdata[7];
    w_ms_mret[7]     = 1'b1;
    w_ms_mret[12:11] = 2'b11;
  end

  assign w_tvec_base = {bus.mtvec_in[XLEN-1:2], 2'b00};
  assign w_tvec = (MTVEC_VECTORED_EN && r_irq &&
                   bus.mtvec_in[1:0] == 2'b01)
                ? w_tvec_base + XLEN'(28)
                : w_tvec_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cause <= '0;
      r_tval  <= '0;
      r_irq   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_redir <= 1'b0;
      r_rpc   <= '0;
    end else begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_redir <= 1'b0;
      r_rpc   <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_evt) begin
            r_pc    <= {bus.pc[XLEN-1:2], 2'b00};
            r_cause <= w_cause;
            r_tval  <= w_tval;
            r_irq   <= w_irq;
            r_we    <= 1'b1;
            if (w_trap) begin
              r_state <= T_MEPC;
              r_addr  <= A_MEPC;
            end else begin
              r_state <= M_MSTATUS;
              r_addr  <= A_MSTATUS;
            end
          end
        end
        T_MEPC: begin
          r_state <= T_MCAUSE;
          r_we    <= 1'b1;
          r_addr  <= A_MCAUSE;
        end
        T_MCAUSE: begin
          r_state <= T_MTVAL;
          r_we    <= 1'b1;
          r_addr  <= A_MTVAL;
        end
        T_MTVAL: begin
          r_state <= T_MSTATUS;
          r_we    <= 1'b1;
          r_addr  <= A_MSTATUS;
        end
        T_MSTATUS: begin
          r_state <= T_REDIR;
          r_redir <= 1'b1;
          r_rpc   <= w_tvec;
        end
        M_MSTATUS: begin
          r_state <= M_REDIR;
          r_redir <= 1'b1;
          r_rpc   <= bus.mepc_in;
        end
        T_REDIR:  r_state <= IDLE;
        M_REDIR:  r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  // IDLE lends the write port to CSR instructions
  always_comb begin
    bus.stall     = 1'b1;
    bus.csr_we    = r_we;
    bus.csr_addr  = r_addr;
    bus.csr_wdata = '0;
    unique case (r_state)
      IDLE: begin
        bus.stall     = w_evt;
        bus.csr_we    = bus.csr_inst_we & ~w_evt;
        bus.csr_addr  = bus.csr_inst_addr;
        bus.csr_wdata = bus.csr_inst_wdata;
      end
      T_MEPC:    bus.csr_wdata = r_pc;
      T_MCAUSE:  bus.csr_wdata = r_cause;
      T_MTVAL:   bus.csr_wdata = r_tval;
      T_MSTATUS: bus.csr_wdata = w_ms_trap;
      M_MSTATUS: bus.csr_wdata = w_ms_mret;
      default:   ;
    endcase
    if (rst) begin
      bus.stall  = 1'b0;
      bus.csr_we = 1'b0;
    end
  end

  assign bus.flush          = r_redir;
  assign bus.redirect_valid = r_redir;
  assign bus.redirect_pc    = r_rpc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations plus
// random traffic against a queue-of-expected-cycles reference model.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(32)) bus ();

  trap_ctrl #(
    .XLEN(32),
    .MTVEC_VECTORED_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] env_csr [0:4095];
  logic [31:0] m_csr   [0:4095];

  assign bus.csr_rdata   = env_csr[bus.csr_addr];
  assign bus.mtvec_in    = env_csr[12'h305];
  assign bus.mepc_in     = env_csr[12'h341];
  assign bus.mstatus_mie = env_csr[12'h300][3];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) env_csr[i] <= '0;
    end else if (bus.csr_we) begin
      env_csr[bus.csr_addr] <= bus.csr_wdata;
    end
  end

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        redir;
    logic [31:0] rpc;
  } step_t;

  step_t       q [$];
  int          errors = 0;
  int          checks = 0;
  logic [11:0] log_a [$];
  logic [31:0] log_d [$];
  int          stall_cnt = 0;
  int          flush_cnt = 0;
  logic [31:0] last_rpc = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] trap_ms(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y[7] = x[3];
    y[3] = 1'b0;
    y[12:11] = 2'b11;
    return y;
  endfunction

  function automatic logic [31:0] mret_ms(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y[3] = x[7];
    y[7] = 1'b1;
    y[12:11] = 2'b11;
    return y;
  endfunction

  task automatic model_step();
    step_t s;
    logic irq, ill, ebr, eca, mr;
    logic [31:0] cause, tval, base, pcv;
    if (q.size() != 0) begin
      s = q.pop_front();
      chk("seq_stall", 32'(bus.stall), 32'd1);
      chk("seq_we", 32'(bus.csr_we), 32'(s.we));
      chk("seq_flush", 32'(bus.flush), 32'(s.redir));
      chk("seq_rv", 32'(bus.redirect_valid), 32'(s.redir));
      chk("seq_rpc", bus.redirect_pc, s.rpc);
      if (s.we) begin
        chk("seq_addr", 32'(bus.csr_addr), 32'(s.addr));
        chk("seq_wdata", bus.csr_wdata, s.wdata);
        m_csr[s.addr] = s.wdata;
      end
    end else begin
      irq = bus.instr_valid & bus.irq_timer & m_csr[12'h300][3];
      ill = bus.instr_valid & bus.is_illegal;
      ebr = bus.instr_valid & bus.is_ebreak;
      eca = bus.instr_valid & bus.is_ecall;
      mr  = bus.instr_valid & bus.is_mret;
      chk("idle_flush", 32'(bus.flush), 32'd0);
      chk("idle_rv", 32'(bus.redirect_valid), 32'd0);
      chk("idle_rpc", bus.redirect_pc, 32'd0);
      chk("idle_addr", 32'(bus.csr_addr), 32'(bus.csr_inst_addr));
      if (irq | ill | ebr | eca | mr) begin
        chk("det_stall", 32'(bus.stall), 32'd1);
        chk("det_we", 32'(bus.csr_we), 32'd0);
        if (irq | ill | ebr | eca) begin
          if (irq)      cause = 32'h8000_0007;
          else if (ill) cause = 32'd2;
          else if (ebr) cause = 32'd3;
          else          cause = 32'd11;
          tval = (!irq && ill) ? bus.bad_instr : 32'd0;
          pcv  = {bus.pc[31:2], 2'b00};
          base = {m_csr[12'h305][31:2], 2'b00};
          if (irq && m_csr[12'h305][1:0] == 2'b01) base = base + 32'd28;
          q.push_back('{1'b1, 12'h341, pcv, 1'b0, 32'h0});
          q.push_back('{1'b1, 12'h342, cause, 1'b0, 32'h0});
          q.push_back('{1'b1, 12'h343, tval, 1'b0, 32'h0});
          q.push_back('{1'b1, 12'h300, trap_ms(m_csr[12'h300]),
                        1'b0, 32'h0});
          q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, base});
        end else begin
          q.push_back('{1'b1, 12'h300, mret_ms(m_csr[12'h300]),
                        1'b0, 32'h0});
          q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, m_csr[12'h341]});
        end
      end else begin
        chk("idle_stall", 32'(bus.stall), 32'd0);
        chk("idle_we", 32'(bus.csr_we), 32'(bus.csr_inst_we));
        chk("idle_wdata", bus.csr_wdata, bus.csr_inst_wdata);
        if (bus.csr_inst_we) m_csr[bus.csr_inst_addr] = bus.csr_inst_wdata;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_flush", 32'(bus.flush), 32'd0);
      chk("rst_rv", 32'(bus.redirect_valid), 32'd0);
      chk("rst_we", 32'(bus.csr_we), 32'd0);
      chk("rst_rpc", bus.redirect_pc, 32'd0);
      q.delete();
      for (int i = 0; i < 4096; i++) m_csr[i] = '0;
    end else begin
      if (bus.csr_we) begin
        log_a.push_back(bus.csr_addr);
        log_d.push_back(bus.csr_wdata);
      end
      if (bus.stall) stall_cnt++;
      if (bus.flush) flush_cnt++;
      if (bus.redirect_valid) last_rpc = bus.redirect_pc;
      model_step();
    end
  end

  task automatic clr_inputs();
    bus.instr_valid    = 1'b0;
    bus.pc             = '0;
    bus.is_ecall       = 1'b0;
    bus.is_ebreak      = 1'b0;
    bus.is_illegal     = 1'b0;
    bus.is_mret        = 1'b0;
    bus.bad_instr      = '0;
    bus.csr_inst_we    = 1'b0;
    bus.csr_inst_addr  = '0;
    bus.csr_inst_wdata = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
    end
    #1;
    chk("wait_idle", 32'(bus.stall), 32'd0);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.csr_inst_we    = 1'b1;
    bus.csr_inst_addr  = a;
    bus.csr_inst_wdata = d;
    @(posedge clk); #1;
    bus.csr_inst_we    = 1'b0;
  endtask

  task automatic trap(input logic [31:0] pc, input logic eca,
                      input logic ebr, input logic ill,
                      input logic mr, input logic [31:0] bad,
                      input bit hold);
    log_a.delete();
    log_d.delete();
    stall_cnt = 0;
    flush_cnt = 0;
    last_rpc  = '0;
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.pc          = pc;
    bus.is_ecall    = eca;
    bus.is_ebreak   = ebr;
    bus.is_illegal  = ill;
    bus.is_mret     = mr;
    bus.bad_instr   = bad;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.is_ecall    = 1'b0;
    bus.is_ebreak   = 1'b0;
    bus.is_illegal  = 1'b0;
    bus.is_mret     = 1'b0;
    if (hold) begin
      repeat (4) begin @(posedge clk); #1; end
      bus.csr_inst_we = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    clr_inputs();
    bus.irq_timer = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    csr_wr(12'h305, 32'h8000_0100);
    csr_wr(12'h300, 32'h0000_0008);
    trap(32'h8000_0010, 1, 0, 0, 0, 32'h0, 0);
    chk("ecall_n", 32'(log_a.size()), 32'd4);
    chk("ecall_a0", 32'(log_a[0]), 32'h341);
    chk("ecall_d0", log_d[0], 32'h8000_0010);
    chk("ecall_a1", 32'(log_a[1]), 32'h342);
    chk("ecall_d1", log_d[1], 32'd11);
    chk("ecall_d2", log_d[2], 32'd0);
    chk("ecall_a3", 32'(log_a[3]), 32'h300);
    chk("ecall_d3", log_d[3], 32'h0000_1880);
    chk("ecall_rpc", last_rpc, 32'h8000_0100);
    chk("ecall_stall", 32'(stall_cnt), 32'd6);
    chk("ecall_flush", 32'(flush_cnt), 32'd1);

    trap(32'h8000_0020, 1, 0, 1, 0, 32'hFFFF_FFFF, 0);
    chk("ill_cause", log_d[1], 32'd2);
    chk("ill_tval", log_d[2], 32'hFFFF_FFFF);

    csr_wr(12'h305, 32'h8000_0101);
    csr_wr(12'h300, 32'h0000_0008);
    bus.irq_timer = 1'b1;
    trap(32'h8000_0030, 1, 0, 0, 0, 32'h0, 0);
    chk("irq_mepc", log_d[0], 32'h8000_0030);
    chk("irq_cause", log_d[1], 32'h8000_0007);
    chk("irq_rpc", last_rpc, 32'h8000_011C);
    trap(32'h8000_0040, 1, 0, 0, 0, 32'h0, 0);
    chk("nomie_cause", log_d[1], 32'd11);
    chk("nomie_rpc", last_rpc, 32'h8000_0100);
    bus.irq_timer = 1'b0;

    csr_wr(12'h300, 32'h0000_1880);
    csr_wr(12'h341, 32'h8000_0014);
    trap(32'h8000_0044, 0, 0, 0, 1, 32'h0, 0);
    chk("mret_n", 32'(log_a.size()), 32'd1);
    chk("mret_ms", log_d[0], 32'h0000_1888);
    chk("mret_rpc", last_rpc, 32'h8000_0014);
    chk("mret_stall", 32'(stall_cnt), 32'd3);

    @(posedge clk); #1;
    bus.csr_inst_we    = 1'b1;
    bus.csr_inst_addr  = 12'h305;
    bus.csr_inst_wdata = 32'h8000_0200;
    #1;
    chk("pt_we", 32'(bus.csr_we), 32'd1);
    chk("pt_addr", 32'(bus.csr_addr), 32'h305);
    chk("pt_wdata", bus.csr_wdata, 32'h8000_0200);
    @(negedge clk); #1;
    trap(32'h8000_0050, 1, 0, 0, 0, 32'h0, 1);
    chk("hold_n", 32'(log_a.size()), 32'd4);
    chk("hold_a0", 32'(log_a[0]), 32'h341);
    chk("hold_a1", 32'(log_a[1]), 32'h342);
    chk("hold_a2", 32'(log_a[2]), 32'h343);
    chk("hold_a3", 32'(log_a[3]), 32'h300);
    chk("hold_rpc", last_rpc, 32'h8000_0200);

    log_a.delete();
    log_d.delete();
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.is_ecall    = 1'b1;
    bus.pc          = 32'h8000_0060;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.is_ecall    = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_we", 32'(bus.csr_we), 32'd0);
    chk("arst_flush", 32'(bus.flush), 32'd0);
    chk("arst_rv", 32'(bus.redirect_valid), 32'd0);
    chk("arst_rpc", bus.redirect_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_log", 32'(log_a.size()), 32'd1);
    trap(32'h8000_0070, 1, 0, 0, 0, 32'h0, 0);
    chk("restart_n", 32'(log_a.size()), 32'd4);
    chk("restart_a0", 32'(log_a[0]), 32'h341);
    chk("restart_d0", log_d[0], 32'h8000_0070);
    chk("restart_stall", 32'(stall_cnt), 32'd6);

    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      bus.instr_valid    = ($urandom % 3) == 0;
      bus.pc             = $urandom;
      bus.is_ecall       = ($urandom % 4) == 0;
      bus.is_ebreak      = ($urandom % 5) == 0;
      bus.is_illegal     = ($urandom % 5) == 0;
      bus.is_mret        = ($urandom % 4) == 0;
      bus.bad_instr      = $urandom;
      bus.irq_timer      = ($urandom % 4) == 0;
      bus.csr_inst_we    = ($urandom % 3) == 0;
      bus.csr_inst_wdata = $urandom;
      case ($urandom % 6)
        0: bus.csr_inst_addr = 12'h300;
        1: bus.csr_inst_addr = 12'h305;
        2: bus.csr_inst_addr = 12'h341;
        3: bus.csr_inst_addr = 12'h342;
        4: bus.csr_inst_addr = 12'h343;
        default: bus.csr_inst_addr = 12'h340;
      endcase
    end
    @(posedge clk); #1;
    clr_inputs();
    bus.irq_timer = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
